// File: rtl/miniproject_pkg.sv
// Shared types and constants for the RGB LED output path.
// Used by the PWM driver and by the colour sequencer.
package miniproject_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int CLK_HZ     = 12_000_000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_duty_t;

  // Map an internal "lit" flag onto the physical pin level.
  function automatic logic pin_level(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_tick_gen.sv
// Free-running prescaler: tick is high for one clk every DIV clks.
// Shared with the colour sequencer for its step timing.
module tick_gen #(
  parameter int DIV = 47
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Prescaler counts 0..DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM output stage with a double-buffered duty triple.
// New duties are taken over only at a period boundary, so no partial periods appear.
module rgb_pwm_driver
  import miniproject_pkg::*;
#(
  parameter int PRESCALE_DIV = 47,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_r,
  input  logic [DUTY_W-1:0] duty_g,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              period_start,
  output logic              RGB_R,
  output logic              RGB_G,
  output logic              RGB_B
);

  logic              tick_s;
  logic              wrap_s;
  logic              accept_s;
  logic [DUTY_W-1:0] pwm_cnt_r;
  rgb_duty_t         pending_r;
  rgb_duty_t         active_r;
  logic              pending_full_r;
  logic              period_start_r;
  logic [2:0]        lit_r;

  tick_gen #(
    .DIV (PRESCALE_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign wrap_s     = tick_s && (pwm_cnt_r == {DUTY_W{1'b1}});
  assign accept_s   = duty_valid && !pending_full_r;
  assign duty_ready = !pending_full_r;

  // PWM step counter, wraps naturally at 2^DUTY_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + DUTY_W'(1);
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Pending/active double buffer; accept and boundary transfer are exclusive
  // because a transfer needs pending_full while an accept needs it clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r      <= '0;
      active_r       <= '0;
      pending_full_r <= 1'b0;
    end else if (wrap_s && pending_full_r) begin
      active_r       <= pending_r;
      pending_full_r <= 1'b0;
    end else if (accept_s) begin
      pending_r      <= '{r: 8'(duty_r), g: 8'(duty_g), b: 8'(duty_b)};
      pending_full_r <= 1'b1;
    end else begin
      pending_full_r <= pending_full_r;
    end
  end

  // Registered period marker and per-channel lit flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start_r <= 1'b0;
      lit_r          <= 3'b000;
    end else begin
      period_start_r <= wrap_s;
      lit_r[2]       <= pwm_cnt_r < DUTY_W'(active_r.r);
      lit_r[1]       <= pwm_cnt_r < DUTY_W'(active_r.g);
      lit_r[0]       <= pwm_cnt_r < DUTY_W'(active_r.b);
    end
  end

  assign period_start = period_start_r;
  assign RGB_R        = pin_level(lit_r[2], ACTIVE_LOW);
  assign RGB_G        = pin_level(lit_r[1], ACTIVE_LOW);
  assign RGB_B        = pin_level(lit_r[0], ACTIVE_LOW);

endmodule
